fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and issues word reads to instruction memory with at most one request outstanding. Returned words go into a 2-entry instruction buffer. The head of the buffer is presented to the decoder as a valid/ready stream carrying the full instruction, its PC, and the pre-split `opcode`/`func` fields. Branch/jump redirects flush the buffer and retarget the PC.

---
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one imem read in flight and
// feeds a 2-entry buffer to the decoder. Define FETCH_PERF_CNT_EN for perf counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_func
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e            state_q;
    logic              req_q;
    logic [31:0]       pc_q;
    logic [31:0]       out_pc_q;
    logic              drop_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              wptr_q;
    logic              rptr_q;
    logic [1:0][31:0]  instr_q;
    logic [1:0][31:0]  ipc_q;

    logic push;
    logic pop;
    logic grant;

    assign push  = (state_q == WAIT) && imem_rvalid && !drop_q;
    assign pop   = id_valid && id_ready;
    assign grant = (state_q == REQ) && imem_gnt;

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            pc_q     <= RESET_PC;
            out_pc_q <= 32'h0;
            drop_q   <= 1'b0;
            count_q  <= 2'd0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            instr_q  <= '0;
            ipc_q    <= '0;
        end else if (redirect_valid) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            pc_q    <= {redirect_pc[31:2], 2'b00};
            // A response still owed by memory must be swallowed before re-issuing.
            if (((state_q == WAIT) && !imem_rvalid) || grant) begin
                drop_q  <= 1'b1;
                state_q <= WAIT;
                req_q   <= 1'b0;
            end else begin
                drop_q  <= 1'b0;
                state_q <= REQ;
                req_q   <= 1'b1;
            end
        end else begin
            if (push) begin
                instr_q[wptr_q] <= imem_rdata;
                ipc_q[wptr_q]   <= out_pc_q;
                wptr_q          <= ~wptr_q;
            end
            if (pop)
                rptr_q <= ~rptr_q;
            count_q <= count_d;

            case (state_q)
                IDLE: begin
                    if (count_q <= 2'd1) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        out_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= WAIT;
                        req_q    <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop_q <= 1'b0;
                        if (count_d <= 2'd1) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign id_valid  = (count_q != 2'd0);
    assign id_instr  = instr_q[rptr_q];
    assign id_pc     = ipc_q[rptr_q];
    assign id_opcode = id_instr[31:26];
    assign id_func   = id_instr[5:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] stall_q;

    // Words discarded by a same-cycle redirect never reach the buffer, so are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= 32'h0;
            stall_q   <= 32'h0;
        end else begin
            if (push && !redirect_valid)
                fetched_q <= fetched_q + 32'd1;
            if (id_valid && !id_ready)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed per-cycle vector bench for fetch_stage (RESET_PC = 0x100).
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  id_opcode;
    logic [5:0]  id_func;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .id_func        (id_func)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied for the coming edge, and outputs expected just before it.
    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   stall_model = 0;

    function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr, input logic vld,
                                input logic [31:0] instr, input logic [31:0] pc);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
        v.req = req; v.addr = addr; v.vld = vld; v.instr = instr; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic [31:0] ei;
        ei = v.instr;
        chk($sformatf("v%0d imem_req", idx), {31'b0, imem_req}, {31'b0, v.req});
        chk($sformatf("v%0d imem_addr", idx), imem_addr, v.addr);
        chk($sformatf("v%0d id_valid", idx), {31'b0, id_valid}, {31'b0, v.vld});
        if (v.vld) begin
            chk($sformatf("v%0d id_instr", idx), id_instr, ei);
            chk($sformatf("v%0d id_pc", idx), id_pc, v.pc);
            chk($sformatf("v%0d id_opcode", idx), {26'b0, id_opcode}, {26'b0, ei[31:26]});
            chk($sformatf("v%0d id_func", idx), {26'b0, id_func}, {26'b0, ei[5:0]});
        end
        imem_gnt       = v.gnt;
        imem_rvalid    = v.rv;
        imem_rdata     = v.rdata;
        id_ready       = v.rdy;
        redirect_valid = v.rd;
        redirect_pc    = v.rpc;
        if (v.vld && !v.rdy) stall_model++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;

        // Sequential fetch, immediate grant, 1-cycle response
        vecs.push_back(mk(0,0,0,1,0,0, 0,32'h100,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 1,32'h100,0,0,0));
        vecs.push_back(mk(0,1,32'h2508_0001,1,0,0, 0,32'h104,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 1,32'h104,1,32'h2508_0001,32'h100));
        vecs.push_back(mk(0,1,32'h8C22_0004,1,0,0, 0,32'h108,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 1,32'h108,1,32'h8C22_0004,32'h104));
        vecs.push_back(mk(0,1,32'h0043_2020,1,0,0, 0,32'h10C,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 1,32'h10C,1,32'h0043_2020,32'h108));
        vecs.push_back(mk(0,0,0,1,0,0, 1,32'h10C,0,0,0));
        // Decoder stalls 10 cycles: buffer fills, requests stop, head stable
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h10C,0,0,0));
        vecs.push_back(mk(0,1,32'h1111_0001,0,0,0, 0,32'h110,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h110,1,32'h1111_0001,32'h10C));
        vecs.push_back(mk(0,1,32'h2222_0002,0,0,0, 0,32'h114,1,32'h1111_0001,32'h10C));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0,0,0,0,0,0, 0,32'h114,1,32'h1111_0001,32'h10C));
        vecs.push_back(mk(0,0,0,1,0,0, 0,32'h114,1,32'h1111_0001,32'h10C));
        vecs.push_back(mk(0,0,0,1,0,0, 0,32'h114,1,32'h2222_0002,32'h110));
        vecs.push_back(mk(1,0,0,1,0,0, 1,32'h114,0,0,0));
        // Redirect while WAIT: late response dropped
        vecs.push_back(mk(0,0,0,1,1,32'h203, 0,32'h118,0,0,0));
        vecs.push_back(mk(0,1,32'hDEAD_BEEF,1,0,0, 0,32'h200,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 1,32'h200,0,0,0));
        vecs.push_back(mk(0,1,32'h3333_0003,1,0,0, 0,32'h204,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 1,32'h204,1,32'h3333_0003,32'h200));
        // Redirect with rvalid and pop in the same cycle, count = 1
        vecs.push_back(mk(0,1,32'h4444_0004,1,1,32'h300, 0,32'h208,1,32'h3333_0003,32'h200));
        // Grant held low, redirect in the third cycle
        vecs.push_back(mk(0,0,0,1,0,0, 1,32'h300,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 1,32'h300,0,0,0));
        vecs.push_back(mk(0,0,0,1,1,32'h400, 1,32'h300,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 1,32'h400,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 1,32'h400,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 1,32'h400,0,0,0));
        vecs.push_back(mk(0,1,32'h5555_0005,1,0,0, 0,32'h404,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 1,32'h404,1,32'h5555_0005,32'h400));
        // Redirect coincident with a grant: that response must be dropped
        vecs.push_back(mk(1,0,0,1,1,32'h500, 1,32'h404,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 0,32'h500,0,0,0));
        vecs.push_back(mk(0,1,32'h6666_0006,1,0,0, 0,32'h500,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 1,32'h500,0,0,0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst imem_addr", imem_addr, 32'h100);
        chk("rst id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst id_instr", id_instr, 32'h0);
        chk("rst id_pc", id_pc, 32'h0);
        chk("rst id_opcode", {26'b0, id_opcode}, 32'h0);
        chk("rst id_func", {26'b0, id_func}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst perf_fetched", perf_fetched, 32'h0);
        chk("rst perf_stall", perf_stall, 32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(i, vecs[i]);

`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'd7);
        chk("perf_stall", perf_stall, stall_model);
`endif

        // Asynchronous reset mid-operation takes effect without a clock edge
        rst_n = 1'b0;
        #1;
        chk("midrst imem_req", {31'b0, imem_req}, 32'h0);
        chk("midrst imem_addr", imem_addr, 32'h100);
        chk("midrst id_valid", {31'b0, id_valid}, 32'h0);
        chk("midrst id_instr", id_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("midrst perf_fetched", perf_fetched, 32'h0);
        chk("midrst perf_stall", perf_stall, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
